rot_decoder: RTL and testbench
==============================

ROT_DECODER -- requirements
Module: rot_decoder

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent quadrature channels, range 1..8.
REQ-002 Parameter WIDTH, default 8: per-channel position counter width, range 2..16.
REQ-003 Parameter DEBOUNCE, default 4: consecutive stable cycles before a synchronised input is accepted, range 1..255.
REQ-004 Parameter SATURATE, default 0: 0 = counter wraps modulo 2^WIDTH; 1 = counter clamps at 0 and 2^WIDTH-1.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 a  in  CHANNELS  quadrature phase A per channel, asynchronous to clk.
REQ-008 b  in  CHANNELS  quadrature phase B per channel, asynchronous to clk.
REQ-009 clear  in  CHANNELS  per-channel single-cycle request to zero the counter.
REQ-010 value  out  CHANNELS*WIDTH  registered counters, channel n at bits [n*WIDTH +: WIDTH].
REQ-011 step_up  out  CHANNELS  one-cycle pulse, coincident with a counter increment.
REQ-012 step_dn  out  CHANNELS  one-cycle pulse, coincident with a counter decrement.
REQ-013 error  out  CHANNELS  one-cycle pulse on an illegal transition (see REQ-030).

Function
REQ-014 Each a/b bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 Per-bit debounce: the filtered bit SHALL take a new synchronised value only after that value has been held for DEBOUNCE consecutive cycles; any change restarts the count.
REQ-016 Phase = {filtered a, filtered b}; forward sequence 00->01->11->10->00, with every forward edge counting +1 (4 counts per detent cycle).
REQ-017 Reverse sequence 00->10->11->01->00, with every reverse edge counting -1.
REQ-018 An unchanged phase SHALL leave value unchanged and assert no pulse.
REQ-019 Latency from a stable raw input edge to the value/step update SHALL be exactly 2 + DEBOUNCE + 1 clk cycles.
REQ-020 step_up/step_dn SHALL be registered and assert in the same cycle as the value change.
REQ-021 SATURATE=0: increment at 2^WIDTH-1 gives 0; decrement at 0 gives 2^WIDTH-1; step pulse still fires.
REQ-022 SATURATE=1: increment at max and decrement at 0 hold value and suppress the step pulse.
REQ-023 clear SHALL set the channel's value to 0 next cycle and take priority over a simultaneous step; that step SHALL be discarded, with no pulse.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be honoured in the same cycle.
REQ-025 After reset release, the first filtered phase of each channel SHALL be captured as baseline ("priming") without counting, whatever the input level at reset.

Reset
REQ-026 While reset=0: value=0, step_up=0, step_dn=0, error=0, debounce counters=0, and priming flags cleared.
REQ-027 Synchroniser and filter registers SHALL load the current pin level during reset so no spurious edge follows release.
REQ-028 A reset asserted mid-transition SHALL abandon the partial debounce count; no step results from it.

Configuration
REQ-029 Macro ROT_DECODER_ERR_EN SHALL enable illegal-transition detection.
REQ-030 With ROT_DECODER_ERR_EN defined: a phase change of both bits at once (00<->11, 01<->10) SHALL pulse error for one cycle, leave value unchanged and adopt the new phase as the baseline.
REQ-031 Without ROT_DECODER_ERR_EN: the error port is tied to 0 and a double-bit change is silently ignored, with the baseline updated.

Structure
REQ-032 Shared package rot_pkg SHALL hold the phase constants (PH_00, PH_01, PH_11, PH_10) and a typedef dir_t {DIR_NONE, DIR_UP, DIR_DN, DIR_ERR}.
REQ-033 Sub-module rot_channel (synchroniser, debounce, decode and counter for one channel) SHALL be instantiated CHANNELS times by generate; rot_decoder only packs the ports.

Verification
REQ-034 DEBOUNCE=4, one forward cycle 00->01->11->10->00, each phase held 10 cycles -> value 0->4, four step_up pulses, each exactly 7 cycles after its raw edge.
REQ-035 Glitch: a held 2 cycles high then low, DEBOUNCE=4 -> no value change and no pulse.
REQ-036 SATURATE=0, WIDTH=8, value=255, one forward edge -> value=0 with step_up; SATURATE=1 -> value stays 255 with no pulse.
REQ-037 clear and a forward edge landing in the same cycle, value=5 -> value=0 next cycle, no step_up.
REQ-038 ERR_EN defined, phase 00->11 directly -> error pulse of 1 cycle, value unchanged; then 11->10 -> +1.
REQ-039 Inputs at 11 through reset release -> value stays 0 and no pulse; channel 1 reversing while channel 0 advances -> both counters update in the same cycle.

Source files
------------

// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - phase constants, direction type and transition decode shared by the rotary decoder
package rot_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN, DIR_ERR} dir_t;

  // Forward order is 00->01->11->10->00; any two-bit jump is illegal.
  function automatic dir_t decode_dir(input logic [1:0] prev, input logic [1:0] cur);
    dir_t d;
    d = DIR_NONE;
    case ({prev, cur})
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: d = DIR_UP;
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: d = DIR_DN;
      default: d = (prev == cur) ? DIR_NONE : DIR_ERR;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rot_channel.sv
// rtl/rot_channel.sv - one quadrature channel: sync, debounce, decode, counter
// ROT_DECODER_ERR_EN enables the registered illegal-transition error pulse.
module rot_channel
  import rot_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             step_up,
  output logic             step_dn,
  output logic             error
);

  localparam logic [7:0]       DB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] VMAX    = {WIDTH{1'b1}};
  localparam bit               SAT     = (SATURATE != 0);

  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      filt;
  logic [1:0][7:0] cnt;
  logic [1:0]      prev;
  logic            primed;
  dir_t            dir;

  assign raw = {a, b};

  // Loading the pin level in reset means release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= raw;
      sync2 <= raw;
      filt  <= raw;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  assign dir = primed ? decode_dir(prev, filt) : DIR_NONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      primed  <= 1'b0;
      prev    <= PH_00;
      value   <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      primed  <= 1'b1;
      prev    <= filt;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      if (clear) begin
        value <= '0;
      end else if (dir == DIR_UP && !(SAT && value == VMAX)) begin
        value   <= value + ONE;
        step_up <= 1'b1;
      end else if (dir == DIR_DN && !(SAT && value == '0)) begin
        value   <= value - ONE;
        step_dn <= 1'b1;
      end
    end
  end

`ifdef ROT_DECODER_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      error <= 1'b0;
    end else begin
      error <= (dir == DIR_ERR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: rtl/rot_decoder.sv
// rtl/rot_decoder.sv - multi-channel quadrature decoder, one rot_channel per channel
// ROT_DECODER_ERR_EN (seen by rot_channel) enables illegal-transition error pulses.
module rot_decoder #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       step_up,
  output logic [CHANNELS-1:0]       step_dn,
  output logic [CHANNELS-1:0]       error
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    rot_channel #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .a       (a[n]),
      .b       (b[n]),
      .clear   (clear[n]),
      .value   (value[n*WIDTH +: WIDTH]),
      .step_up (step_up[n]),
      .step_dn (step_dn[n]),
      .error   (error[n])
    );
  end

endmodule

// File: tb/tb_rot_decoder.sv
// tb/tb_rot_decoder.sv - self-checking bench for rot_decoder (wrapping and saturating builds)
module tb_rot_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  a, b, clear;
  logic [15:0] value;
  logic [1:0]  step_up, step_dn, error;
  logic [0:0]  a2, b2, clear2;
  logic [1:0]  value2;
  logic [0:0]  step_up2, step_dn2, error2;

  always #5 clk = ~clk;

  rot_decoder #(.CHANNELS(2), .WIDTH(8), .DEBOUNCE(4), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear),
    .value(value), .step_up(step_up), .step_dn(step_dn), .error(error)
  );

  rot_decoder #(.CHANNELS(1), .WIDTH(2), .DEBOUNCE(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .a(a2), .b(b2), .clear(clear2),
    .value(value2), .step_up(step_up2), .step_dn(step_dn2), .error(error2)
  );

  int         checks = 0;
  int         failures = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         ph [3];
  int         mval [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    logic [1:0] p;
    for (int c = 0; c < 2; c++) begin
      p = seq[ph[c]];
      a[c] = p[1];
      b[c] = p[0];
    end
    p = seq[ph[2]];
    a2[0] = p[1];
    b2[0] = p[0];
  endtask

  function automatic int next_val(input int c, input int d);
    int delta, v;
    delta = (d == 2) ? 0 : d;
    v = mval[c] + delta;
    if (c < 2) return ((v % 256) + 256) % 256;
    if (v < 0) return 0;
    if (v > 3) return 3;
    return v;
  endfunction

  task automatic check_all(input string w, input logic [1:0] eu, input logic [1:0] ed,
                           input logic [1:0] ee, input logic eu2, input logic ed2);
    chk({w, ".value0"}, 32'(value[7:0]), mval[0]);
    chk({w, ".value1"}, 32'(value[15:8]), mval[1]);
    chk({w, ".step_up"}, 32'(step_up), 32'(eu));
    chk({w, ".step_dn"}, 32'(step_dn), 32'(ed));
    chk({w, ".error"}, 32'(error), 32'(ee));
    chk({w, ".sat_value"}, 32'(value2), mval[2]);
    chk({w, ".sat_step_up"}, 32'(step_up2), 32'(eu2));
    chk({w, ".sat_step_dn"}, 32'(step_dn2), 32'(ed2));
    chk({w, ".sat_error"}, 32'(error2), 32'd0);
  endtask

  // d: -1 reverse, 0 hold, 1 forward, 2 double-bit jump. The count must land 7 cycles after the raw edge.
  task automatic step(input int d0, input int d1, input int d2, input logic [1:0] clr);
    int         d [3];
    int         nv [3];
    logic [1:0] eu, ed, ee;
    logic       eu2, ed2;
    d  = '{d0, d1, d2};
    eu = '0; ed = '0; ee = '0;
    for (int c = 0; c < 3; c++) begin
      nv[c] = next_val(c, d[c]);
      ph[c] = (ph[c] + d[c] + 4) % 4;
    end
    for (int c = 0; c < 2; c++) begin
      if (clr[c]) nv[c] = 0;
      else begin
        eu[c] = (d[c] == 1);
        ed[c] = (d[c] == -1);
      end
`ifdef ROT_DECODER_ERR_EN
      ee[c] = (d[c] == 2);
`endif
    end
    eu2 = (d[2] == 1) && (nv[2] != mval[2]);
    ed2 = (d[2] == -1) && (nv[2] != mval[2]);
    drive();
    repeat (6) tick();
    check_all("pre", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    clear = clr;
    tick();
    clear = 2'b00;
    mval = nv;
    check_all("edge", eu, ed, ee, eu2, ed2);
    tick();
    check_all("post", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) tick();
  endtask

  task automatic clear_all();
    clear = 2'b11;
    clear2 = 1'b1;
    tick();
    clear = 2'b00;
    clear2 = 1'b0;
    mval = '{0, 0, 0};
    check_all("clear", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  function automatic int rand_dir(input bit allow_err);
    int r;
    r = int'($urandom_range(0, allow_err ? 3 : 2));
    return (r == 3) ? 2 : r - 1;
  endfunction

  initial begin
    clear = 2'b00;
    clear2 = 1'b0;
    mval = '{0, 0, 0};
    ph = '{2, 0, 0};
    reset = 1'b0;
    drive();
    repeat (3) tick();
    check_all("reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (10) begin
      tick();
      check_all("prime", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    end

    repeat (4) step(1, 1, 1, 2'b00);
    repeat (2) step(1, -1, -1, 2'b00);

    a[0] = ~a[0];
    repeat (2) tick();
    a[0] = ~a[0];
    repeat (12) begin
      tick();
      check_all("glitch", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    end

    clear_all();
    step(-1, 0, -1, 2'b00);
    step(1, 0, 1, 2'b00);
    repeat (5) step(1, 0, 0, 2'b00);
    step(1, 1, 0, 2'b01);

    step(2, 0, 0, 2'b00);
    step(1, 2, 0, 2'b00);

    repeat (24) step(rand_dir(1'b1), rand_dir(1'b1), rand_dir(1'b0), 2'b00);

    ph[1] = (ph[1] + 1) % 4;
    drive();
    repeat (4) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    mval = '{0, 0, 0};
    repeat (10) begin
      tick();
      check_all("midreset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    end
    step(1, -1, 1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
